// File: rtl/div_arbiter_pkg.sv
// Shared state encoding and float helpers for the divider arbiter.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_arb_state_t;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] qnan(input int exp_bits, input int mant_bits);
    logic [63:0] pat;
    pat = ((64'd1 << exp_bits) - 64'd1) << mant_bits;
    pat = pat | (64'd1 << (mant_bits - 1));
    return pat;
  endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module rr_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic             found;
  logic             hit;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    hit       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx       = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      hit       = ~found & req_valid[idx];
      grant     = grant | ({NUM_REQ{hit}} & (ONE << idx));
      grant_idx = hit ? idx : grant_idx;
      found     = found | hit;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider among NUM_REQ requesters, one operation at a time,
// with a watchdog that answers with QNaN if the divider never responds.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int MANT_BITS = 10,
  parameter int EXP_BITS  = 5,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 64,
  localparam int W     = EXP_BITS + MANT_BITS + 1,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int TMR_W = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [W-1:0]         resp_data,
  output logic                 resp_timeout,
  output logic                 div_input_valid,
  output logic [W-1:0]         div_in_a,
  output logic [W-1:0]         div_in_b,
  input  logic [W-1:0]         div_data_out,
  input  logic                 div_output_valid,
  output logic                 busy,
  output logic                 err_sticky
);

  localparam logic [W-1:0]       QNAN     = W'(qnan(EXP_BITS, MANT_BITS));
  localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  div_arb_state_t   state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [TMR_W-1:0] timer;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;
  logic               owner_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The request handshake is only open while idle; grant already implies valid.
  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
  end

  // One-hot OR mux of the granted requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | (req_a[i*W +: W] & {W{grant[i]}});
      sel_b = sel_b | (req_b[i*W +: W] & {W{grant[i]}});
    end
  end

  // Non-owner resp_ready bits are deliberately ignored.
  always_comb begin
    owner_ready = |(resp_ready & (ONE << owner));
  end

  // Main sequencer: accept, issue, wait with watchdog, return response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      timer           <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      resp_timeout    <= 1'b0;
      div_input_valid <= 1'b0;
      div_in_a        <= '0;
      div_in_b        <= '0;
      busy            <= 1'b0;
      err_sticky      <= 1'b0;
    end else begin
      div_input_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            div_in_a        <= sel_a;
            div_in_b        <= sel_b;
            owner           <= grant_idx;
            div_input_valid <= 1'b1;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A real result beats the watchdog when both land in the same cycle.
          if (div_output_valid) begin
            resp_data    <= div_data_out;
            resp_timeout <= 1'b0;
            resp_valid   <= ONE << owner;
            state        <= RESP;
          end else if (timer == TMR_LAST) begin
            resp_data    <= QNAN;
            resp_timeout <= 1'b1;
            err_sticky   <= 1'b1;
            resp_valid   <= ONE << owner;
            state        <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (owner_ready) begin
            resp_valid <= '0;
            rr_ptr     <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
